// File: rtl/wb_mux_pkg.sv
// Shared types and helpers for the Wishbone slave fan-out (wb_slave_mux).
package wb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Slave-index width; a single slave still needs one index bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_mux_decode.sv
// Combinational address-window decoder: selects the slave for a user-area address.
module wb_mux_decode
  import wb_mux_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned WIN_BITS   = 16,
  parameter int unsigned IDXW       = clog2_min1(NUM_SLAVES)
) (
  input  logic [31:0]     adr,
  output logic            hit,
  output logic [IDXW-1:0] idx
);

  localparam int unsigned TAG_SHIFT = WIN_BITS + IDXW;

  logic tag_match;

  assign idx       = adr[WIN_BITS +: IDXW];
  assign tag_match = (adr >> TAG_SHIFT) == (BASE_ADDR >> TAG_SHIFT);
  assign hit       = tag_match && (32'(idx) < NUM_SLAVES);

endmodule

// File: rtl/wb_slave_mux.sv
// Wishbone fan-out from the management SoC port to NUM_SLAVES user peripherals.
// Optional bus timeout is enabled by defining WB_MUX_TIMEOUT_EN.
module wb_slave_mux
  import wb_mux_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned WIN_BITS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_SLAVES-1:0]    m_cyc_o,
  output logic [NUM_SLAVES-1:0]    m_stb_o,
  output logic                     m_we_o,
  output logic [3:0]               m_sel_o,
  output logic [31:0]              m_adr_o,
  output logic [31:0]              m_dat_o,
  input  logic [NUM_SLAVES-1:0]    m_ack_i,
  input  logic [32*NUM_SLAVES-1:0] m_dat_i,
  output logic                     err_o
);

  localparam int unsigned IDXW = clog2_min1(NUM_SLAVES);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("wb_slave_mux: parameter out of range");
  end

  state_t          state, state_nxt;
  logic            req, hit, sel_ack, timeout;
  logic [IDXW-1:0] idx, idx_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [NUM_SLAVES-1:0] sel_onehot;

  wb_mux_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .WIN_BITS   (WIN_BITS),
    .IDXW       (IDXW)
  ) u_decode (
    .adr (wbs_adr_i),
    .hit (hit),
    .idx (idx)
  );

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign sel_ack = m_ack_i[idx_q];

`ifdef WB_MUX_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Held at zero outside BUSY, so it is clear on every entry to BUSY.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                   tmo_cnt <= '0;
    else if (state != BUSY)           tmo_cnt <= '0;
    else if (!sel_ack)                tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign timeout = (state == BUSY) && ((tmo_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = hit ? BUSY : RESP;
      BUSY: begin
        if (!wbs_cyc_i)              state_nxt = IDLE;
        else if (sel_ack || timeout) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Broadcast fields only move on a mapped request; unmapped writes leave them untouched.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      idx_q   <= '0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == IDLE && req) begin
      if (hit) begin
        idx_q   <= idx;
        m_we_o  <= wbs_we_i;
        m_sel_o <= wbs_sel_i;
        m_adr_o <= wbs_adr_i;
        m_dat_o <= wbs_dat_i;
        err_q   <= 1'b0;
      end else begin
        rdata_q <= ERR_DATA;
        err_q   <= 1'b1;
      end
    end else if (state == BUSY && wbs_cyc_i) begin
      if (sel_ack) begin
        rdata_q <= m_dat_i[32*idx_q +: 32];
        err_q   <= 1'b0;
      end else if (timeout) begin
        rdata_q <= ERR_DATA;
        err_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    sel_onehot        = '0;
    sel_onehot[idx_q] = 1'b1;
  end

  assign m_cyc_o   = (state == BUSY) ? sel_onehot : '0;
  assign m_stb_o   = (state == BUSY) ? sel_onehot : '0;
  assign wbs_ack_o = (state == RESP);
  assign wbs_dat_o = (state == RESP) ? rdata_q : '0;
  assign err_o     = (state == RESP) && err_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed self-checking bench for wb_slave_mux (honours WB_MUX_TIMEOUT_EN).
module tb_wb_slave_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic [3:0]   m_cyc, m_stb;
  logic         m_we;
  logic [3:0]   m_sel;
  logic [31:0]  m_adr, m_dat;
  logic [3:0]   m_ack;
  logic [127:0] m_rdat;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_slave_mux #(
    .NUM_SLAVES     (4),
    .BASE_ADDR      (32'h3000_0000),
    .WIN_BITS       (16),
    .TIMEOUT_CYCLES (8),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .m_cyc_o   (m_cyc),
    .m_stb_o   (m_stb),
    .m_we_o    (m_we),
    .m_sel_o   (m_sel),
    .m_adr_o   (m_adr),
    .m_dat_o   (m_dat),
    .m_ack_i   (m_ack),
    .m_dat_i   (m_rdat),
    .err_o     (err)
  );

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
  endtask

  task automatic bus_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
  endtask

  task automatic test_reset();
    checks++; if ({ack, err, m_we} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {ack, err, m_we}); end
    checks++; if ({m_cyc, m_stb, m_sel} !== 12'h000) begin errors++; $display("FAIL reset_strobes: got %h expected 000", {m_cyc, m_stb, m_sel}); end
    checks++; if ({rdat, m_adr, m_dat} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {rdat, m_adr, m_dat}); end
  endtask

  task automatic test_read();
    int bad = 0;
    bus_req(0, 32'h3002_0010, 32'h0, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (m_stb !== 4'b0100 || m_cyc !== 4'b0100 || ack !== 1'b0) bad++;
      if (c == 4) begin m_ack = 4'b0100; m_rdat[64 +: 32] = 32'h1234_5678; end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL read_busy: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL read_ack: got %b expected 10", {ack, err}); end
    checks++; if (rdat !== 32'h1234_5678) begin errors++; $display("FAIL read_data: got %h expected 12345678", rdat); end
    checks++; if (m_stb !== 4'b0000) begin errors++; $display("FAIL read_stb_drop: got %b expected 0000", m_stb); end
    m_ack = '0; bus_idle();
    @(negedge clk);
    checks++; if ({ack, rdat} !== 33'h0) begin errors++; $display("FAIL read_after: got %h expected 0", {ack, rdat}); end
  endtask

  task automatic test_write();
    bus_req(1, 32'h3000_0004, 32'hA5A5_A5A5, 4'b0011);
    @(negedge clk);
    checks++; if (m_stb !== 4'b0001) begin errors++; $display("FAIL write_stb: got %b expected 0001", m_stb); end
    checks++; if ({m_we, m_sel} !== 5'b10011) begin errors++; $display("FAIL write_we_sel: got %b expected 10011", {m_we, m_sel}); end
    checks++; if (m_dat !== 32'hA5A5_A5A5) begin errors++; $display("FAIL write_dat: got %h expected a5a5a5a5", m_dat); end
    checks++; if (m_adr !== 32'h3000_0004) begin errors++; $display("FAIL write_adr: got %h expected 30000004", m_adr); end
    m_ack = 4'b0001;
    @(negedge clk);
    checks++; if ({ack, err, m_stb} !== 6'b100000) begin errors++; $display("FAIL write_ack: got %b expected 100000", {ack, err, m_stb}); end
    m_ack = '0; bus_idle();
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_single_ack: got %b expected 0", ack); end
  endtask

  task automatic test_unmapped();
    bus_req(0, 32'h3004_0000, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if ({ack, err, m_stb} !== 6'b110000) begin errors++; $display("FAIL unmapped_rd_ack: got %b expected 110000", {ack, err, m_stb}); end
    checks++; if (rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unmapped_rd_data: got %h expected deadbeef", rdat); end
    bus_idle();
    @(negedge clk);
    checks++; if ({ack, err} !== 2'b00) begin errors++; $display("FAIL unmapped_pulse: got %b expected 00", {ack, err}); end
    bus_req(1, 32'h4000_0000, 32'h0BAD_0BAD, 4'hF);
    @(negedge clk);
    checks++; if ({ack, err, m_stb} !== 6'b110000) begin errors++; $display("FAIL unmapped_wr_ack: got %b expected 110000", {ack, err, m_stb}); end
    checks++; if (m_dat !== 32'hA5A5_A5A5) begin errors++; $display("FAIL unmapped_wr_discard: got %h expected a5a5a5a5", m_dat); end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic test_wrong_ack();
    bus_req(0, 32'h3001_0000, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (m_stb !== 4'b0010) begin errors++; $display("FAIL wrongack_stb: got %b expected 0010", m_stb); end
    m_ack = 4'b0001; m_rdat[0 +: 32] = 32'h1111_1111;
    @(negedge clk);
    checks++; if ({ack, m_stb} !== 5'b00010) begin errors++; $display("FAIL wrongack_ignored: got %b expected 00010", {ack, m_stb}); end
    m_ack = 4'b0010; m_rdat[32 +: 32] = 32'h2222_2222;
    @(negedge clk);
    checks++; if ({ack, rdat} !== {1'b1, 32'h2222_2222}) begin errors++; $display("FAIL wrongack_resp: got %h expected 122222222", {ack, rdat}); end
    m_ack = '0; bus_idle();
    @(negedge clk);
  endtask

  task automatic test_timeout();
`ifdef WB_MUX_TIMEOUT_EN
    int busy = 0;
    logic got = 0;
    bus_req(0, 32'h3001_0000, 32'h0, 4'hF);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack) begin got = 1; break; end
      if (m_stb == 4'b0010) busy++;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL timeout_ack: got %b expected 1", got); end
    checks++; if (busy !== 8) begin errors++; $display("FAIL timeout_busy_cycles: got %0d expected 8", busy); end
    checks++; if ({err, rdat} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL timeout_resp: got %h expected 1deadbeef", {err, rdat}); end
    bus_idle();
    @(negedge clk);
    bus_req(0, 32'h3001_0000, 32'h0, 4'hF);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) begin m_ack = 4'b0010; m_rdat[32 +: 32] = 32'h5A5A_5A5A; end
    end
    @(negedge clk);
    checks++; if ({ack, err, rdat} !== {2'b10, 32'h5A5A_5A5A}) begin errors++; $display("FAIL timeout_ack_wins: got %h expected 25a5a5a5a", {ack, err, rdat}); end
    m_ack = '0; bus_idle();
    @(negedge clk);
`else
    int acks = 0;
    int bad = 0;
    bus_req(0, 32'h3001_0000, 32'h0, 4'hF);
    repeat (1000) begin
      @(negedge clk);
      if (ack) acks++;
      if (m_stb !== 4'b0010) bad++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL notimeout_acks: got %0d expected 0", acks); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL notimeout_stb: got %0d bad cycles expected 0", bad); end
    bus_idle();
    @(negedge clk);
    checks++; if (m_stb !== 4'b0000) begin errors++; $display("FAIL notimeout_abort: got %b expected 0000", m_stb); end
`endif
  endtask

  task automatic test_abort_reset();
    int acks = 0;
    int bad = 0;
    bus_req(0, 32'h3003_0000, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (m_stb !== 4'b1000) begin errors++; $display("FAIL abort_stb: got %b expected 1000", m_stb); end
    bus_idle();
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
      if (m_stb !== 4'b0000) bad++;
    end
    checks++; if ({acks, bad} !== {32'd0, 32'd0}) begin errors++; $display("FAIL abort: got acks=%0d bad=%0d expected 0 0", acks, bad); end
    bus_req(0, 32'h3002_0000, 32'h0, 4'hF);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if ({m_cyc, m_stb} !== 8'h00) begin errors++; $display("FAIL reset_midbusy: got %h expected 00", {m_cyc, m_stb}); end
    bus_idle();
    @(negedge clk);
    rst_n = 1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL reset_no_ack: got %0d expected 0", acks); end
    bus_req(0, 32'h3003_0000, 32'h0, 4'hF);
    @(negedge clk);
    m_ack = 4'b1000; m_rdat[96 +: 32] = 32'hCAFE_0003;
    @(negedge clk);
    checks++; if ({ack, rdat} !== {1'b1, 32'hCAFE_0003}) begin errors++; $display("FAIL followup_read: got %h expected 1cafe0003", {ack, rdat}); end
    m_ack = '0; bus_idle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    bus_idle();
    m_ack = '0;
    m_rdat = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_read();
    test_write();
    test_unmapped();
    test_wrong_ack();
    test_timeout();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_slave_mux.md
# wb_slave_mux

Parametrised Wishbone fan-out between the management SoC Wishbone slave port and NUM_SLAVES user peripherals inside the user project area. Each request is decoded by address window, registered, and forwarded to exactly one downstream slave. The block returns a single-cycle ack with registered read data. Unmapped addresses and (optionally) stalled slaves are terminated with an error response, so the management core never hangs.

## Interface
Parameters:
- NUM_SLAVES, 4, number of downstream slaves (1..16)
- BASE_ADDR, 32'h3000_0000, base of the user window
- WIN_BITS, 16, log2 of the byte size of each slave window
- TIMEOUT_CYCLES, 255, BUSY cycles before forced termination (1..65535)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports (IDXW = max(1, clog2(NUM_SLAVES))):
- wb_clk_i  in  1  single clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  upstream Wishbone control
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  address / write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with wbs_ack_o
- m_cyc_o, m_stb_o  out  NUM_SLAVES each  per-slave one-hot cycle/strobe
- m_we_o  out  1, m_sel_o  out  4, m_adr_o  out  32, m_dat_o  out  32  broadcast, registered
- m_ack_i  in  NUM_SLAVES  per-slave acknowledge
- m_dat_i  in  32*NUM_SLAVES  per-slave read data, slave i at [32*i +: 32]
- err_o  out  1  one-cycle pulse on an unmapped access or timeout

## Operation
- Hit: wbs_adr_i[31:WIN_BITS+IDXW] == BASE_ADDR[31:WIN_BITS+IDXW] and idx = wbs_adr_i[WIN_BITS +: IDXW] < NUM_SLAVES.
- FSM states: IDLE, BUSY, RESP.
- IDLE, wbs_cyc_i & wbs_stb_i, hit: latch we/sel/adr/dat and idx, then go to BUSY. m_cyc_o[idx] and m_stb_o[idx] are asserted from the next cycle.
- IDLE, request, miss: go to RESP with ERR_DATA and pulse err_o. A write is discarded and produces no downstream activity.
- BUSY, m_ack_i[idx]: capture m_dat_i[idx], drop m_cyc_o/m_stb_o, then go to RESP.
- BUSY, wbs_cyc_i low: abort. Drop the strobes and go to IDLE with no ack.
- RESP: wbs_ack_o = 1 for exactly one cycle, wbs_dat_o = captured data, then go to IDLE.
- wbs_dat_o is 0 whenever wbs_ack_o is 0.
- m_ack_i bits are ignored when the block is not in BUSY or when the bit is not the selected index.
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Reset is asynchronous at any point, including mid-BUSY. The strobes drop immediately, and no ack is produced after release.

## Timing
- Request sampled in cycle 0. m_stb_o is high in cycle 1.
- A slave ack in cycle k (k ≥ 1) gives wbs_ack_o in cycle k+1.
- Minimum latency: wbs_ack_o in cycle 2. The unmapped-access error ack is in cycle 1.
- The next request is accepted no earlier than the cycle after RESP. There are no back-to-back acks.
- The timeout counter clears on entry to BUSY and increments on each BUSY cycle without an ack. It terminates the access when the count reaches TIMEOUT_CYCLES.
- If the ack and the timeout fall in the same cycle, the ack wins and normal data is returned.

## Configuration
- WB_MUX_TIMEOUT_EN defined: the timeout counter is present. On expiry the block drops the strobes, enters RESP with ERR_DATA, and pulses err_o coincident with wbs_ack_o.
- WB_MUX_TIMEOUT_EN undefined: the counter and the TIMEOUT_CYCLES logic are removed. BUSY waits indefinitely for an ack or an abort, and err_o signals only unmapped accesses.

## Structure
- Package wb_mux_pkg holds:
  - the state enum (IDLE/BUSY/RESP)
  - the default ERR_DATA constant
  - the clog2-with-minimum-1 function used for IDXW
- Sub-module wb_mux_decode: a combinational address decoder with outputs hit and idx. It is instantiated once.

## Test plan
- Read slave 2 at 0x3002_0010, slave acks 3 cycles after its strobe with 0x1234_5678 -> wbs_ack_o one cycle later with 0x1234_5678. Only m_stb_o[2] is ever high.
- Write 0xA5A5_A5A5, sel 4'b0011 to slave 0 at 0x3000_0004 -> m_dat_o = 0xA5A5_A5A5, m_sel_o = 4'b0011 and m_we_o = 1 while m_stb_o[0] is high, then one ack.
- Read 0x3004_0000 with NUM_SLAVES=4 (unmapped) -> ack in cycle 1 with 0xDEAD_BEEF, err_o pulses, all m_stb_o stay 0.
- With WB_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave 1 never acks -> strobe drops after 8 BUSY cycles, ack with 0xDEAD_BEEF, err_o pulses. Without the macro, no ack within 1000 cycles.
- Drop wbs_cyc_i while in BUSY, or assert wb_rst_ni low mid-access -> strobes drop, no wbs_ack_o. A following read to slave 3 completes normally.
- Slave 0 asserts m_ack_i[0] while slave 1 is selected -> the ack is ignored, and the transaction completes only on m_ack_i[1].
